latch_result_checker: RTL
=========================

# latch_result_checker

Downstream consumer of the latch top's three parallel 4-bit outputs (SystemVerilog, Verilog and VHDL implementations of the same latch). It samples the three results on a strobe and forms a bitwise majority vote. It counts disagreements and captures the first mismatching sample for debug. It is synthesizable and sits between the latch top and the board/bench status outputs, so a run of vectors ends in a single pass/fail summary.

## Interface
Parameters:
- W, 4, data width of each compared result.
- CNT_W, 16, width of sample/error counters and sample-index fields.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a run (honoured only in IDLE).
- stop  in  1  end a run early (honoured only in RUN).
- clear  in  1  synchronous clear of all results, return to IDLE.
- num_samples  in  CNT_W  samples per run, latched at start; 0 = unbounded (run until stop).
- sample_en  in  1  compare strobe; the three inputs are valid this cycle.
- q_a, q_b, q_c  in  W each  SV, Verilog, VHDL latch results.
- voted  out  W  registered bitwise majority of last sample.
- mismatch  out  1  one-cycle pulse: last sample had any disagreement.
- disagree_mask  out  3  bit0/1/2 set if q_a/q_b/q_c differed from voted on last sample.
- sample_count  out  CNT_W  samples taken this run.
- err_count  out  CNT_W  mismatching samples, saturating.
- first_err_valid  out  1  sticky: first-mismatch capture populated.
- first_err_index  out  CNT_W  sample_count value (0-based) of first mismatch.
- first_err_a, first_err_b, first_err_c  out  W each  inputs at first mismatch.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 → RUN, latch num_samples, zero sample_count, err_count, first_err_*.
- RUN: each sample_en=1 cycle performs one compare:
  - voted ← (a&b)|(a&c)|(b&c) bitwise.
  - disagree_mask[i] ← (input i ≠ majority); mismatch ← |disagree_mask.
  - sample_count +1, wrapping at 2^CNT_W-1 → 0.
  - err_count +1 if mismatch, saturating at all-ones.
  - If mismatch and !first_err_valid: capture index (pre-increment sample_count), a, b, c; set first_err_valid.
- RUN → DONE when stop=1, or when num_samples≠0 and the incremented sample_count equals num_samples.
- DONE holds all results; start ignored; clear → IDLE.
- clear in any state: → IDLE, zero every output except voted/disagree_mask, which also zero. clear beats start, stop and sample_en in the same cycle.
- sample_en outside RUN: ignored, no output change.
- start while already in RUN: ignored.

## Timing
- Reset (rst_n=0, immediate): state IDLE; voted=0, mismatch=0, disagree_mask=0, sample_count=0, err_count=0, first_err_*=0, busy=0, done=0.
- Compare latency 1 cycle: voted, disagree_mask, mismatch, counters and capture valid the cycle after sample_en.
- mismatch high exactly one cycle per mismatching sample; low on non-sample cycles. voted/disagree_mask hold their values between samples.
- busy asserts the cycle after start; done asserts the cycle after the terminating sample or stop.
- stop and sample_en together: the sample is counted, then DONE.
- Final-sample mismatch: err_count and capture include it; done and the final mismatch pulse appear in the same cycle.
- rst_n asserted mid-run aborts immediately; no partial results retained.

## Test plan
- Reset, start num_samples=4, four samples with a=b=c=4'hA → voted=4'hA, mismatch never high, err_count=0, sample_count=4, done=1 after 4th sample.
- Samples (5,5,5),(3,3,7),(9,1,9) → second: voted=3, mask=3'b100, first_err_index=1, first_err_c=7; third: voted=9, mask=3'b010; err_count=2, first_err unchanged.
- num_samples=0, 70000 mismatching samples, then stop → err_count=16'hFFFF saturated, sample_count=70000 mod 65536=4464, done=1.
- clear, start and sample_en asserted together in RUN → next cycle IDLE, all counters 0, sample not counted.
- rst_n pulsed low mid-run after 2 errors → all outputs 0 immediately, IDLE; sample_en before the next start ignored.
- stop coincident with mismatching sample → err_count includes it, done=1 next cycle; later samples change nothing.

Source files
------------

// File: rtl/latch_result_checker.sv
// rtl/latch_result_checker.sv - majority vote and mismatch tracking across three parallel latch results
module latch_result_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sample_en,
  input  logic [W-1:0]     q_a,
  input  logic [W-1:0]     q_b,
  input  logic [W-1:0]     q_c,
  output logic [W-1:0]     voted,
  output logic             mismatch,
  output logic [2:0]       disagree_mask,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_index,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic [W-1:0]     first_err_c,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_num;
  logic [W-1:0]     w_maj;
  logic [2:0]       w_mask;
  logic             w_mismatch;
  logic             w_sample;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_err_sat;

  assign w_maj      = (q_a & q_b) | (q_a & q_c) | (q_b & q_c);
  assign w_mask     = {(q_c != w_maj), (q_b != w_maj), (q_a != w_maj)};
  assign w_mismatch = |w_mask;
  assign w_sample   = (r_state == S_RUN) && sample_en;
  assign w_cnt_inc  = sample_count + 1'b1;
  // A zero num_samples means an unbounded run that only stop can end.
  assign w_last     = w_sample && (r_num != '0) && (w_cnt_inc == r_num);
  assign w_err_sat  = (err_count == {CNT_W{1'b1}});

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_RUN;
        S_RUN:   if (stop || w_last) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num           <= '0;
      voted           <= '0;
      mismatch        <= 1'b0;
      disagree_mask   <= '0;
      sample_count    <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_c     <= '0;
    end else if (clear) begin
      r_num           <= '0;
      voted           <= '0;
      mismatch        <= 1'b0;
      disagree_mask   <= '0;
      sample_count    <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_c     <= '0;
    end else begin
      mismatch <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_num           <= num_samples;
        sample_count    <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_index <= '0;
        first_err_a     <= '0;
        first_err_b     <= '0;
        first_err_c     <= '0;
      end
      if (w_sample) begin
        voted         <= w_maj;
        disagree_mask <= w_mask;
        mismatch      <= w_mismatch;
        sample_count  <= w_cnt_inc;
        if (w_mismatch && !w_err_sat) err_count <= err_count + 1'b1;
        // Index is the pre-increment count, so the first sample of a run is 0.
        if (w_mismatch && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_index <= sample_count;
          first_err_a     <= q_a;
          first_err_b     <= q_b;
          first_err_c     <= q_c;
        end
      end
    end
  end

endmodule
